// File: rtl/host_src_pkt_arbiter.sv
// Packet-granular 2:1 round-robin arbiter onto the host-bound AXI4-Stream; optional stats via HOST_ARB_STATS_EN.
// Latency: tvalid in IDLE -> tready next cycle -> beat on m_axis one cycle later; 1 beat/cycle within a packet.
// Backpressure: one-deep output register; granted input's tready = !out_vld || m_axis_tready.
module host_src_pkt_arbiter #(
    parameter int DATA_BITS = 512,
    parameter int ID_BITS   = 6
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   s0_axis_tvalid,
    output logic                   s0_axis_tready,
    input  logic [DATA_BITS-1:0]   s0_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s0_axis_tkeep,
    input  logic                   s0_axis_tlast,
    input  logic [ID_BITS-1:0]     s0_axis_tid,
    input  logic                   s1_axis_tvalid,
    output logic                   s1_axis_tready,
    input  logic [DATA_BITS-1:0]   s1_axis_tdata,
    input  logic [DATA_BITS/8-1:0] s1_axis_tkeep,
    input  logic                   s1_axis_tlast,
    input  logic [ID_BITS-1:0]     s1_axis_tid,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_BITS-1:0]   m_axis_tdata,
    output logic [DATA_BITS/8-1:0] m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [ID_BITS-1:0]     m_axis_tid,
    output logic                   m_axis_src,
`ifdef HOST_ARB_STATS_EN
    output logic [31:0]            pkt_cnt0,
    output logic [31:0]            pkt_cnt1,
`endif
    output logic                   arb_busy
);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t                 state_q, state_d;
    logic                   rr_q, rr_d;
    logic                   busy_q, busy_d;
    logic                   out_vld_q, out_vld_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic [DATA_BITS/8-1:0] keep_q, keep_d;
    logic                   last_q, last_d;
    logic [ID_BITS-1:0]     id_q, id_d;
    logic                   src_q, src_d;
    logic                   out_free, ld0, ld1, load;

    assign out_free       = !out_vld_q || m_axis_tready;
    assign s0_axis_tready = (state_q == GRANT0) && out_free;
    assign s1_axis_tready = (state_q == GRANT1) && out_free;
    assign ld0            = s0_axis_tvalid && s0_axis_tready;
    assign ld1            = s1_axis_tvalid && s1_axis_tready;
    assign load           = ld0 || ld1;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        out_vld_d = out_vld_q;
        data_d    = data_q;
        keep_d    = keep_q;
        last_d    = last_q;
        id_d      = id_q;
        src_d     = src_q;

        case (state_q)
            IDLE: begin
                if (s0_axis_tvalid && s1_axis_tvalid)
                    state_d = rr_q ? GRANT1 : GRANT0;
                else if (s0_axis_tvalid)
                    state_d = GRANT0;
                else if (s1_axis_tvalid)
                    state_d = GRANT1;
            end
            GRANT0: begin
                // Hand straight to the other input on tlast; never re-grant the same one directly.
                if (ld0 && s0_axis_tlast) begin
                    rr_d    = 1'b1;
                    state_d = s1_axis_tvalid ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                if (ld1 && s1_axis_tlast) begin
                    rr_d    = 1'b0;
                    state_d = s0_axis_tvalid ? GRANT0 : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (ld0) begin
            data_d = s0_axis_tdata;
            keep_d = s0_axis_tkeep;
            last_d = s0_axis_tlast;
            id_d   = s0_axis_tid;
            src_d  = 1'b0;
        end else if (ld1) begin
            data_d = s1_axis_tdata;
            keep_d = s1_axis_tkeep;
            last_d = s1_axis_tlast;
            id_d   = s1_axis_tid;
            src_d  = 1'b1;
        end

        if (load)
            out_vld_d = 1'b1;
        else if (m_axis_tready)
            out_vld_d = 1'b0;

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            rr_q      <= 1'b0;
            busy_q    <= 1'b0;
            out_vld_q <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
            id_q      <= '0;
            src_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            busy_q    <= busy_d;
            out_vld_q <= out_vld_d;
            data_q    <= data_d;
            keep_q    <= keep_d;
            last_q    <= last_d;
            id_q      <= id_d;
            src_q     <= src_d;
        end
    end

    assign m_axis_tvalid = out_vld_q;
    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tid    = id_q;
    assign m_axis_src    = src_q;
    assign arb_busy      = busy_q;

`ifdef HOST_ARB_STATS_EN
    logic [31:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [31:0] pkt_cnt1_q, pkt_cnt1_d;

    always_comb begin
        pkt_cnt0_d = pkt_cnt0_q + 32'(ld0 && s0_axis_tlast);
        pkt_cnt1_d = pkt_cnt1_q + 32'(ld1 && s1_axis_tlast);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
        end else begin
            pkt_cnt0_q <= pkt_cnt0_d;
            pkt_cnt1_q <= pkt_cnt1_d;
        end
    end

    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;
`endif

endmodule

// File: tb/tb_host_src_pkt_arbiter.sv
// Bench for host_src_pkt_arbiter: queue-driven producers, scoreboard of expected output beats.
module tb_host_src_pkt_arbiter;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic         last;
        logic [5:0]   id;
        logic         src;
    } beat_t;

    logic         aclk = 1'b0;
    logic         aresetn;
    logic         s0_axis_tvalid, s0_axis_tready, s0_axis_tlast;
    logic [511:0] s0_axis_tdata;
    logic [63:0]  s0_axis_tkeep;
    logic [5:0]   s0_axis_tid;
    logic         s1_axis_tvalid, s1_axis_tready, s1_axis_tlast;
    logic [511:0] s1_axis_tdata;
    logic [63:0]  s1_axis_tkeep;
    logic [5:0]   s1_axis_tid;
    logic         m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_src;
    logic [511:0] m_axis_tdata;
    logic [63:0]  m_axis_tkeep;
    logic [5:0]   m_axis_tid;
    logic         arb_busy;
`ifdef HOST_ARB_STATS_EN
    logic [31:0]  pkt_cnt0, pkt_cnt1;
`endif

    host_src_pkt_arbiter #(.DATA_BITS(512), .ID_BITS(6)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tready(s0_axis_tready),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep),
        .s0_axis_tlast(s0_axis_tlast), .s0_axis_tid(s0_axis_tid),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tready(s1_axis_tready),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep),
        .s1_axis_tlast(s1_axis_tlast), .s1_axis_tid(s1_axis_tid),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tid(m_axis_tid),
        .m_axis_src(m_axis_src),
`ifdef HOST_ARB_STATS_EN
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
`endif
        .arb_busy(arb_busy)
    );

    always #5 aclk = ~aclk;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    beat_t s0_q[$];
    beat_t s1_q[$];
    beat_t exp_q[$];
    int    beat_cyc[$];

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [599:0] obs, input logic [599:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input bit src, input int n, input logic [5:0] id,
                            input logic [63:0] lkeep, input logic [7:0] tag);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.data = {32{tag, 8'(i)}};
            b.keep = (i == n - 1) ? lkeep : '1;
            b.last = (i == n - 1);
            b.id   = id;
            b.src  = src;
            if (src) s1_q.push_back(b);
            else     s0_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    // Producers: present the head of their queue, retire it one edge after a handshake.
    initial begin : drv0
        bit acc;
        s0_axis_tvalid = 0; s0_axis_tdata = '0; s0_axis_tkeep = '0;
        s0_axis_tlast = 0; s0_axis_tid = '0;
        forever begin
            @(negedge aclk);
            acc = s0_axis_tvalid && s0_axis_tready;
            @(posedge aclk);
            #1;
            if (acc && s0_q.size() > 0) s0_q.delete(0);
            if (s0_q.size() > 0) begin
                s0_axis_tvalid = 1; s0_axis_tdata = s0_q[0].data; s0_axis_tkeep = s0_q[0].keep;
                s0_axis_tlast = s0_q[0].last; s0_axis_tid = s0_q[0].id;
            end else s0_axis_tvalid = 0;
        end
    end

    initial begin : drv1
        bit acc;
        s1_axis_tvalid = 0; s1_axis_tdata = '0; s1_axis_tkeep = '0;
        s1_axis_tlast = 0; s1_axis_tid = '0;
        forever begin
            @(negedge aclk);
            acc = s1_axis_tvalid && s1_axis_tready;
            @(posedge aclk);
            #1;
            if (acc && s1_q.size() > 0) s1_q.delete(0);
            if (s1_q.size() > 0) begin
                s1_axis_tvalid = 1; s1_axis_tdata = s1_q[0].data; s1_axis_tkeep = s1_q[0].keep;
                s1_axis_tlast = s1_q[0].last; s1_axis_tid = s1_q[0].id;
            end else s1_axis_tvalid = 0;
        end
    end

    initial begin : monitor
        beat_t cur, prev;
        bit    prev_stall;
        prev_stall = 0;
        prev = '0;
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                cur.data = m_axis_tdata; cur.keep = m_axis_tkeep; cur.last = m_axis_tlast;
                cur.id = m_axis_tid; cur.src = m_axis_src;
                if (prev_stall) chk("stall_hold", 600'(cur), 600'(prev));
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) chk("unexpected_beat", 600'(cur), 600'(0));
                    else begin
                        chk("beat", 600'(cur), 600'(exp_q[0]));
                        exp_q.delete(0);
                    end
                    beat_cyc.push_back(cyc);
                end
                prev = cur;
                prev_stall = m_axis_tvalid && !m_axis_tready;
            end else prev_stall = 0;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_beats(input int target, input bit s1_idle, input string tag);
        int k;
        for (k = 0; k < 200 && beat_cyc.size() < target; k++) begin
            @(negedge aclk);
            if (s1_idle) chk("s1_tready_idle", 600'(s1_axis_tready), 600'(0));
        end
        chk({tag, "_beats"}, 600'(beat_cyc.size() >= target), 600'(1));
    endtask

    task automatic wait_drain(input string tag);
        int k;
        for (k = 0; k < 300; k++) begin
            @(negedge aclk);
            if (exp_q.size() == 0 && s0_q.size() == 0 && s1_q.size() == 0 && !m_axis_tvalid) break;
        end
        chk({tag, "_drained"}, 600'(exp_q.size()), 600'(0));
        repeat (2) @(negedge aclk);
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 0;
        s0_q.delete(); s1_q.delete(); exp_q.delete();
        repeat (3) @(negedge aclk);
        aresetn = 1;
        @(negedge aclk);
    endtask

    initial begin : stim
        int          t0, base, idle_cnt;
        bit          saw_busy;
        logic [3:0]  pat;
`ifdef HOST_ARB_STATS_EN
        logic [31:0] c1;
`endif
        aresetn = 0;
        m_axis_tready = 1;
        repeat (3) @(negedge aclk);
        chk("rst_m_tvalid", 600'(m_axis_tvalid), 600'(0));
        chk("rst_s0_tready", 600'(s0_axis_tready), 600'(0));
        chk("rst_s1_tready", 600'(s1_axis_tready), 600'(0));
        chk("rst_busy", 600'(arb_busy), 600'(0));
        chk("rst_src", 600'(m_axis_src), 600'(0));
        chk("rst_payload", 600'({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid}), 600'(0));
        chk("rst_rr", 600'(dut.rr_q), 600'(0));
        aresetn = 1;
        repeat (2) @(negedge aclk);

        // Single 4-beat packet from s0
        base = beat_cyc.size();
        t0 = cyc;
        push_pkt(0, 4, 6'd3, 64'h0000_0000_0000_FFFF, 8'h10);
        wait_beats(base + 4, 1, "single");
        chk("single_first_cyc", 600'(beat_cyc[base]), 600'(t0 + 3));
        chk("single_last_cyc", 600'(beat_cyc[base + 3]), 600'(t0 + 6));
        wait_drain("single");

        // Contention straight after reset: s0 first, then alternate with no gaps
        do_reset();
        base = beat_cyc.size();
        t0 = cyc;
        push_pkt(0, 3, 6'd1, '1, 8'h20);
        push_pkt(1, 3, 6'd2, '1, 8'h21);
        push_pkt(0, 3, 6'd1, '1, 8'h22);
        push_pkt(1, 3, 6'd2, '1, 8'h23);
        wait_beats(base + 12, 0, "contend");
        chk("contend_first_cyc", 600'(beat_cyc[base]), 600'(t0 + 3));
        chk("contend_no_gap", 600'(beat_cyc[base + 11] - beat_cyc[base]), 600'(11));
        wait_drain("contend");

        // Backpressure on a 5-beat s1 packet
        base = beat_cyc.size();
        pat = 4'b1001;
        push_pkt(1, 5, 6'd9, 64'h0000_0000_0000_00FF, 8'h30);
        for (int k = 0; k < 200 && beat_cyc.size() < base + 5; k++) begin
            @(posedge aclk);
            #1;
            m_axis_tready = pat[3 - (k % 4)];
        end
        @(posedge aclk);
        #1;
        m_axis_tready = 1;
        chk("bp_beats", 600'(beat_cyc.size() - base), 600'(5));
        wait_drain("bp");

        // Same-input back-to-back costs exactly one IDLE cycle
        push_pkt(0, 2, 6'd4, '1, 8'h40);
        push_pkt(0, 2, 6'd4, '1, 8'h41);
        saw_busy = 0;
        idle_cnt = 0;
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) begin
            @(negedge aclk);
            if (arb_busy) saw_busy = 1;
            if (saw_busy && !arb_busy && s0_q.size() > 0) idle_cnt++;
        end
        chk("repeat_idle_cycles", 600'(idle_cnt), 600'(1));
        wait_drain("repeat");

        // Asynchronous reset in the middle of a 6-beat packet
        base = beat_cyc.size();
        push_pkt(0, 6, 6'd5, '1, 8'h50);
        wait_beats(base + 2, 0, "midrst");
        #1;
        aresetn = 0;
        s0_q.delete(); exp_q.delete();
        #1;
        chk("midrst_m_tvalid", 600'(m_axis_tvalid), 600'(0));
        chk("midrst_s0_tready", 600'(s0_axis_tready), 600'(0));
        chk("midrst_s1_tready", 600'(s1_axis_tready), 600'(0));
        repeat (2) @(negedge aclk);
        aresetn = 1;
        @(negedge aclk);
        chk("midrst_rr", 600'(dut.rr_q), 600'(0));
        base = beat_cyc.size();
        t0 = cyc;
        push_pkt(1, 3, 6'd7, 64'h0F, 8'h60);
        wait_beats(base + 3, 0, "post_rst");
        chk("post_rst_first_cyc", 600'(beat_cyc[base]), 600'(t0 + 3));
        wait_drain("post_rst");

`ifdef HOST_ARB_STATS_EN
        c1 = pkt_cnt1;
        @(negedge aclk);
        force dut.pkt_cnt0_q = 32'hFFFF_FFFF;
        @(posedge aclk);
        #1;
        release dut.pkt_cnt0_q;
        @(negedge aclk);
        chk("cnt0_preload", 600'(pkt_cnt0), 600'(32'hFFFF_FFFF));
        push_pkt(0, 2, 6'd8, '1, 8'h70);
        wait_drain("stats");
        chk("cnt0_wrap", 600'(pkt_cnt0), 600'(0));
        chk("cnt1_hold", 600'(pkt_cnt1), 600'(c1));
`endif

        chk("scoreboard_empty", 600'(exp_q.size()), 600'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
